// File: rtl/vec_pkg.sv
// Shared types for the XY vector drawer: FSM states and the signed
// Bresenham error type used at the default coordinate width.
package vec_pkg;
  localparam int COORD_W = 8;

  typedef enum logic {IDLE, DRAW} state_t;

  typedef logic signed [COORD_W+1:0] err_t;
endpackage

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: both axis tests use the pre-step e2,
// so a diagonal move updates x, y and err together.
module bresenham_step #(
  parameter int COORD_W = 8
) (
  input  logic        [COORD_W-1:0] x,
  input  logic        [COORD_W-1:0] y,
  input  logic signed [COORD_W+1:0] err,
  input  logic signed [COORD_W+1:0] dx,
  input  logic signed [COORD_W+1:0] dy,
  input  logic                      sx,
  input  logic                      sy,
  output logic        [COORD_W-1:0] nx,
  output logic        [COORD_W-1:0] ny,
  output logic signed [COORD_W+1:0] nerr
);
  logic signed [COORD_W+1:0] e2, ex, ey;
  logic step_x, step_y;

  // sx/sy are direction bits: 1 means decrement
  always_comb begin
    e2     = err <<< 1;
    step_x = (e2 >= dy);
    step_y = (e2 <= dx);
    ex     = step_x ? dy : '0;
    ey     = step_y ? dx : '0;
    nerr   = err + ex + ey;
    nx     = x;
    ny     = y;
    if (step_x) nx = sx ? x - COORD_W'(1) : x + COORD_W'(1);
    if (step_y) ny = sy ? y - COORD_W'(1) : y + COORD_W'(1);
  end
endmodule

// File: rtl/vector_line_drawer.sv
// Rasterises one segment per handshake into held XY DAC codes, each point
// dwelling DWELL cycles so beam brightness stays even along the line.
module vector_line_drawer #(
  parameter int COORD_W = vec_pkg::COORD_W,
  parameter int DWELL   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seg_valid,
  output logic               seg_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] xdac,
  output logic [COORD_W-1:0] ydac,
  output logic               pt_strobe,
  output logic               busy
);
  import vec_pkg::*;

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  typedef logic signed [COORD_W+1:0] serr_t;

  state_t             state;
  logic [COORD_W-1:0] xe, ye, nx, ny;
  serr_t              dx, dy, err, nerr, dx_in, dy_in;
  logic               sx, sy;
  logic [CNT_W-1:0]   cnt;
  logic [COORD_W-1:0] adx, ady;

  always_comb begin
    adx   = (x1 >= x0) ? x1 - x0 : x0 - x1;
    ady   = (y1 >= y0) ? y1 - y0 : y0 - y1;
    dx_in = $signed({2'b00, adx});
    dy_in = -$signed({2'b00, ady});
  end

  bresenham_step #(.COORD_W(COORD_W)) u_step (
    .x(xdac), .y(ydac), .err(err), .dx(dx), .dy(dy), .sx(sx), .sy(sy),
    .nx(nx), .ny(ny), .nerr(nerr)
  );

  assign seg_ready = (state == IDLE);
  assign busy      = (state == DRAW);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      xdac      <= '0;
      ydac      <= '0;
      pt_strobe <= 1'b0;
      xe        <= '0;
      ye        <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          pt_strobe <= 1'b0;
          if (seg_valid) begin
            xdac      <= x0;
            ydac      <= y0;
            xe        <= x1;
            ye        <= y1;
            dx        <= dx_in;
            dy        <= dy_in;
            err       <= dx_in + dy_in;
            sx        <= (x1 < x0);
            sy        <= (y1 < y0);
            cnt       <= '0;
            pt_strobe <= 1'b1;
            state     <= DRAW;
          end
        end
        DRAW: begin
          if (cnt == CNT_W'(DWELL - 1)) begin
            cnt <= '0;
            if (xdac == xe && ydac == ye) begin
              pt_strobe <= 1'b0;
              state     <= IDLE;
            end else begin
              xdac      <= nx;
              ydac      <= ny;
              err       <= nerr;
              pt_strobe <= 1'b1;
            end
          end else begin
            cnt       <= cnt + CNT_W'(1);
            pt_strobe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/vector_line_drawer.md
# vector_line_drawer

- Rasterises straight line segments into a stream of 8-bit X/Y DAC codes for the oscilloscope XY display.
- Sits between the image point source and the DAC pins: accepts one endpoint pair per handshake and walks the beam from start to end with Bresenham stepping.
- Holds each point for a programmable dwell so beam brightness stays uniform along the segment.

## Interface

Parameters:
- `COORD_W`, default 8: coordinate and DAC code width.
- `DWELL`, default 1: clock cycles each point is held, ≥1.

Ports:
- `clk` in, 1: single clock.
- `reset` in, 1: synchronous, active-high.
- `seg_valid` in, 1: a segment is offered on `x0`/`y0`/`x1`/`y1`.
- `seg_ready` out, 1: drawer can accept a segment.
- `x0` in, COORD_W: start X.
- `y0` in, COORD_W: start Y.
- `x1` in, COORD_W: end X.
- `y1` in, COORD_W: end Y.
- `xdac` out, COORD_W: current beam X code.
- `ydac` out, COORD_W: current beam Y code.
- `pt_strobe` out, 1: pulses on the first cycle a new point appears on `xdac`/`ydac`.
- `busy` out, 1: a segment is being drawn.

## Operation

States:
- IDLE:
  - `seg_ready`=1, `busy`=0.
  - `xdac`/`ydac` hold the last drawn point.
- DRAW:
  - `seg_ready`=0, `busy`=1.

Transitions and stepping:
- Handshake in IDLE (`seg_valid & seg_ready`):
  - Latch x0, y0, x1, y1.
  - Compute `dx=|x1-x0|`, `dy=-|y1-y0|`, `sx/sy` = +1 or −1 (+1 when equal), `err=dx+dy`.
  - Load x0/y0 into the output registers.
  - Go to DRAW.
- Inputs are ignored outside the handshake cycle. Later changes to them do not affect the segment in progress.
- DRAW, dwell counter counts 0..DWELL−1. When the count reaches DWELL−1:
  - If current point == (x1,y1): go to IDLE.
  - Otherwise step with `e2=2*err`:
    - if `e2>=dy`: `err+=dy`, `x+=sx`;
    - if `e2<=dx`: `err+=dx`, `y+=sy`.
    - Both tests use the same pre-step `e2`, and both updates may apply in the same cycle.
- `err`/`e2` are signed, COORD_W+2 bits. No coordinate ever leaves the inclusive box spanned by the endpoints, so there is no wrap.
- Points per segment = max(dx,|dy|)+1, endpoints inclusive.
- Degenerate segment (x0==x1, y0==y1): exactly one point, held DWELL cycles.
- `pt_strobe`=1 on the cycle after the handshake, and on each cycle after a step.

Reset:
- Reset values: `xdac`=0, `ydac`=0, `pt_strobe`=0, `busy`=0, `seg_ready`=1, state IDLE.
- Reset mid-segment discards that segment. On the next cycle the block is in IDLE with outputs at 0.

## Timing

- Handshake at edge N: `xdac`/`ydac`=x0/y0 and `pt_strobe`=1 after edge N (visible in cycle N+1).
- Point k (0-based) is first visible in cycle N+1+k·DWELL.
- Last point is visible through cycle N+P·DWELL, where P is the point count. `seg_ready` rises in cycle N+P·DWELL+1.
- Minimum gap between segments: 1 IDLE cycle. Next handshake can occur at edge N+P·DWELL+1.
- `seg_ready` is a pure state decode, with no combinational path from `seg_valid`.
- Outputs are registered, with no combinational path from inputs to `xdac`/`ydac`.

## Structure

- Shared package `vec_pkg`:
  - `COORD_W` default constant;
  - state enum (IDLE, DRAW);
  - signed error type of width COORD_W+2.
- Single module. The Bresenham step (err, e2 and both compares) is natural as the combinational sub-module `bresenham_step`: inputs are x, y, err, dx, dy, sx, sy; outputs are next x, next y, next err.

## Test plan

- DWELL=1, (0,0)->(3,0):
  - points (0,0),(1,0),(2,0),(3,0) in cycles N+1..N+4, `pt_strobe` on every one of them;
  - `seg_ready` high at N+5.
- DWELL=1, (10,10)->(6,13): points (10,10),(9,11),(8,12),(7,12)→(6,13)?
  - Check the sequence against a reference Bresenham model.
  - Requirement: 5 points, final point (6,13).
- DWELL=3, (5,5)->(5,5):
  - single point (5,5) held 3 cycles, one `pt_strobe`;
  - `busy` high for exactly 3 cycles.
- Full diagonal (0,0)->(255,255), DWELL=1: 256 points, every step increments both X and Y by 1, no wrap.
- Reset asserted mid-segment (0,0)->(100,0) at point 40:
  - next cycle `xdac`=0, `busy`=0, `seg_ready`=1;
  - a new segment (1,1)->(2,1) then draws correctly.
- Back-to-back: `seg_valid` held high with changing inputs:
  - each segment is accepted only when `seg_ready`=1, with a 1-cycle idle gap;
  - inputs changed during DRAW have no effect.
